// File: rtl/sub_bytes_engine_if.sv
// Handshake bundle for the byte-substitution engine: input state with mode,
// output state, valid/ready on both sides.
interface sub_bytes_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes / InvSubBytes over a 128-bit state, LANES bytes per beat.
// Mode is latched per transaction; the forward/inverse mux follows the S-boxes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | in_ready high, waiting for a state to accept
// BUSY  | substituting LANES bytes per cycle, cnt selects the slice
// DONE  | out_valid high, result held until out_ready
module sub_bytes_engine #(
    parameter int LANES = 4
) (
    input  logic                clk,
    input  logic                rst,
    sub_bytes_engine_if.slave   bus
);

    localparam int BEATS = 16 / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_chk
        $error("sub_bytes_engine: LANES must be one of 1,2,4,8,16");
    end

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [127:0]    data_q, data_d;
    logic            inv_q, inv_d;
    logic [7:0]      sub_w [LANES];

    // One forward and one inverse lookup per lane; the mode only picks the result.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] byte_w;
        logic [7:0] fwd_w;
        logic [7:0] inv_w;
        assign byte_w   = data_q[(int'(cnt_q) * LANES + l) * 8 +: 8];
        assign fwd_w    = SBOX[byte_w];
        assign inv_w    = INV_SBOX[byte_w];
        assign sub_w[l] = inv_q ? inv_w : fwd_w;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        inv_d   = inv_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    inv_d   = bus.in_inv;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                for (int l = 0; l < LANES; l++) begin
                    data_d[(int'(cnt_q) * LANES + l) * 8 +: 8] = sub_w[l];
                end
                if (cnt_q == CW'(BEATS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            inv_q   <= inv_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_data  = data_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: one instance per legal LANES value, checked against
// an S-box model built from GF(2^8) inversion and the AES affine map.
module tb_sub_bytes_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [4:0]   in_valid_a, in_inv_a, out_ready_a;
    logic [4:0]   in_ready_a, out_valid_a;
    logic [127:0] in_data_a  [5];
    logic [127:0] out_data_a [5];

    for (genvar g = 0; g < 5; g++) begin : g_dut
        sub_bytes_engine_if ifc ();
        assign ifc.in_valid    = in_valid_a[g];
        assign ifc.in_data     = in_data_a[g];
        assign ifc.in_inv      = in_inv_a[g];
        assign ifc.out_ready   = out_ready_a[g];
        assign in_ready_a[g]   = ifc.in_ready;
        assign out_valid_a[g]  = ifc.out_valid;
        assign out_data_a[g]   = ifc.out_data;
        sub_bytes_engine #(.LANES(1 << g)) dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc)
        );
    end

    int n_err    = 0;
    int n_checks = 0;
    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_math(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        if (x == 8'h00) r = 8'h00;
        else for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[i*8 +: 8] = inv ? inv_t[d[i*8 +: 8]] : fwd_t[d[i*8 +: 8]];
        return r;
    endfunction

    task automatic txn(input int k, input logic [127:0] d, input logic inv,
                       output logic [127:0] res, output int lat);
        int w = 0;
        while (!in_ready_a[k] && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("ready_wait_k%0d", k), 128'(w < 50), 128'(1));
        in_valid_a[k]  = 1'b1;
        in_data_a[k]   = d;
        in_inv_a[k]    = inv;
        out_ready_a[k] = 1'b0;
        @(negedge clk);
        in_valid_a[k] = 1'b0;
        chk($sformatf("busy_in_ready_k%0d", k), 128'(in_ready_a[k]), 128'(0));
        lat = 0;
        while (!out_valid_a[k] && lat < 40) begin
            in_data_a[k] = {$urandom, $urandom, $urandom, $urandom};
            in_inv_a[k]  = 1'($urandom_range(1, 0));
            @(negedge clk);
            lat++;
        end
        res = out_data_a[k];
        out_ready_a[k] = 1'b1;
        @(negedge clk);
        out_ready_a[k] = 1'b0;
        chk($sformatf("post_hs_in_ready_k%0d", k), 128'(in_ready_a[k]), 128'(1));
        chk($sformatf("post_hs_out_valid_k%0d", k), 128'(out_valid_a[k]), 128'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] tv_in, tv_out, all63, res, hold, d;
        int           lat, k, w;
        logic         inv;

        tv_in  = {<<8{128'h193de3bea0f4e22b9ac68d2ae9f84808}};
        tv_out = {<<8{128'hd42711aee0bf98f1b8b45de51e415230}};
        all63  = {16{8'h63}};

        for (int i = 0; i < 256; i++) fwd_t[i] = sbox_math(8'(i));
        for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);

        in_valid_a  = '0;
        in_inv_a    = '0;
        out_ready_a = '0;
        for (int i = 0; i < 5; i++) in_data_a[i] = '0;
        rst = 1'b1;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rst_in_ready_k%0d", i), 128'(in_ready_a[i]), 128'(1));
            chk($sformatf("rst_out_valid_k%0d", i), 128'(out_valid_a[i]), 128'(0));
            chk($sformatf("rst_out_data_k%0d", i), out_data_a[i], 128'(0));
        end

        // Forward and inverse on the LANES=4 instance
        txn(2, tv_in, 1'b0, res, lat);
        chk("fwd_vec", res, tv_out);
        chk("fwd_lat", 128'(lat), 128'(4));
        txn(2, tv_out, 1'b1, res, lat);
        chk("inv_vec", res, tv_in);
        txn(2, all63, 1'b1, res, lat);
        chk("inv_all63", res, 128'(0));

        // Backpressure
        in_valid_a[2] = 1'b1;
        in_data_a[2]  = tv_in;
        in_inv_a[2]   = 1'b0;
        @(negedge clk);
        in_valid_a[2] = 1'b0;
        w = 0;
        while (!out_valid_a[2] && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("bp_valid_seen", 128'(out_valid_a[2]), 128'(1));
        hold = out_data_a[2];
        chk("bp_data", hold, tv_out);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_stable", out_data_a[2], hold);
            chk("bp_in_ready_low", 128'(in_ready_a[2]), 128'(0));
            chk("bp_valid_held", 128'(out_valid_a[2]), 128'(1));
        end
        out_ready_a[2] = 1'b1;
        @(negedge clk);
        out_ready_a[2] = 1'b0;
        chk("bp_release_in_ready", 128'(in_ready_a[2]), 128'(1));
        chk("bp_release_out_valid", 128'(out_valid_a[2]), 128'(0));

        // Reset in the middle of BUSY at beat 2
        in_valid_a[2] = 1'b1;
        in_data_a[2]  = tv_in;
        in_inv_a[2]   = 1'b0;
        @(negedge clk);
        in_valid_a[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 128'(in_ready_a[2]), 128'(1));
        chk("midrst_out_valid", 128'(out_valid_a[2]), 128'(0));
        chk("midrst_out_data", out_data_a[2], 128'(0));
        txn(2, 128'(0), 1'b0, res, lat);
        chk("midrst_fresh", res, all63);

        // LANES sweep with the reference vector
        for (int i = 0; i < 5; i++) begin
            txn(i, tv_in, 1'b0, res, lat);
            chk($sformatf("sweep_data_k%0d", i), res, tv_out);
            chk($sformatf("sweep_lat_k%0d", i), 128'(lat), 128'(16 >> i));
        end

        // Random states, modes and lane counts against the model
        for (int n = 0; n < 12; n++) begin
            k   = int'($urandom_range(4, 0));
            d   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(1, 0));
            txn(k, d, inv, res, lat);
            chk($sformatf("rand%0d_data_k%0d", n, k), res, model(d, inv));
            chk($sformatf("rand%0d_lat_k%0d", n, k), 128'(lat), 128'(16 >> k));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
